// File: rtl/module_keypad_decoder.sv
// Keypad return path: column sync, press/release debounce, key code out.
// Optional ASCII mapping on ascii_o when KEYPAD_ASCII_EN is defined.
//
// Ports:
//   clk          system clock
//   rst_n_i      async active-low reset
//   row_i[1:0]   scan row currently driven
//   col_i[3:0]   raw column lines, active-low
//   hold_o       key qualifying/held; freezes the scan counter
//   key_valid_o  one-cycle pulse on an accepted press
//   key_code_o   {row,col} of the last accepted key
//   ascii_o      ASCII of the last accepted key (8'h00 without macro)
module module_keypad_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic [1:0] row_i,
  input  logic [3:0] col_i,
  output logic       hold_o,
  output logic       key_valid_o,
  output logic [3:0] key_code_o,
  output logic [7:0] ascii_o
);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W:0]   cnt_inc;
  logic             done;
  logic [3:0]       sync1, sync2;
  logic [3:0]       act;
  logic             any;
  logic [1:0]       enc;
  logic [1:0]       row_q, col_q;
  logic             load;
  logic             accept;
  logic             match;
  logic             valid_q;
  logic [3:0]       code_q;

  assign act     = ~sync2;
  assign any     = |act;
  assign match   = (act == (4'b0001 << col_q));
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  // Done when this increment lands on the terminal value; the detection
  // cycle in IDLE already counts as the first stable sample.
  assign done    = (cnt_inc >= {1'b0, TERM});

  always_comb begin
    enc = 2'd0;
    if (act[0])      enc = 2'd0;
    else if (act[1]) enc = 2'd1;
    else if (act[2]) enc = 2'd2;
    else if (act[3]) enc = 2'd3;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    load      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          load      = 1'b1;
          state_nxt = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (!match) begin
          state_nxt = IDLE;
        end else if (done) begin
          accept    = 1'b1;
          state_nxt = PRESSED;
        end else begin
          cnt_nxt = cnt_inc[CNT_W-1:0];
        end
      end
      PRESSED: begin
        if (!any) state_nxt = DEB_RELEASE;
      end
      DEB_RELEASE: begin
        if (any) begin
          state_nxt = PRESSED;
        end else if (done) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc[CNT_W-1:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    hold_o      = (state != IDLE);
    key_valid_o = valid_q;
    key_code_o  = code_q;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1   <= 4'hF;
      sync2   <= 4'hF;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      valid_q <= 1'b0;
      code_q  <= 4'h0;
    end else begin
      sync1   <= col_i;
      sync2   <= sync1;
      valid_q <= accept;
      if (load) begin
        row_q <= row_i;
        col_q <= enc;
      end
      if (accept) code_q <= {row_q, col_q};
    end
  end

`ifdef KEYPAD_ASCII_EN
  function automatic logic [7:0] to_ascii(input logic [3:0] c);
    logic [7:0] a;
    unique case (c)
      4'h0: a = 8'h31;
      4'h1: a = 8'h32;
      4'h2: a = 8'h33;
      4'h3: a = 8'h41;
      4'h4: a = 8'h34;
      4'h5: a = 8'h35;
      4'h6: a = 8'h36;
      4'h7: a = 8'h42;
      4'h8: a = 8'h37;
      4'h9: a = 8'h38;
      4'hA: a = 8'h39;
      4'hB: a = 8'h43;
      4'hC: a = 8'h2A;
      4'hD: a = 8'h30;
      4'hE: a = 8'h23;
      4'hF: a = 8'h44;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  logic [7:0] ascii_q;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i)    ascii_q <= 8'h00;
    else if (accept) ascii_q <= to_ascii({row_q, col_q});
  end

  assign ascii_o = ascii_q;
`else
  assign ascii_o = 8'h00;
`endif

endmodule

// File: tb/tb_module_keypad_decoder.sv
// Directed bench for module_keypad_decoder with DEBOUNCE_CYCLES=4.
// Expected codes/timings are hand-derived constants.
module tb_module_keypad_decoder;

  logic       clk = 1'b0;
  logic       rst_n_i = 1'b0;
  logic [1:0] row_i = 2'd0;
  logic [3:0] col_i = 4'hF;
  logic       hold_o;
  logic       key_valid_o;
  logic [3:0] key_code_o;
  logic [7:0] ascii_o;

  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;
  int consec = 0;
  logic prev_v = 1'b0;
  int base;

  always #5 clk = ~clk;

  module_keypad_decoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n_i     (rst_n_i),
    .row_i       (row_i),
    .col_i       (col_i),
    .hold_o      (hold_o),
    .key_valid_o (key_valid_o),
    .key_code_o  (key_code_o),
    .ascii_o     (ascii_o)
  );

  always @(negedge clk) begin
    if (key_valid_o) pulses++;
    if (key_valid_o && prev_v) consec++;
    prev_v = key_valid_o;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] asc(input logic [7:0] a);
`ifdef KEYPAD_ASCII_EN
    return a;
`else
    return 8'h00;
`endif
  endfunction

  initial begin
    // Reset state
    step(2);
    check("rst_hold", hold_o, 0);
    check("rst_valid", key_valid_o, 0);
    check("rst_code", key_code_o, 0);
    check("rst_ascii", ascii_o, 0);
    rst_n_i = 1'b1;
    step(2);

    // Clean press: row 1, col 2 -> code 6
    base = pulses;
    row_i = 2'd1;
    col_i = 4'b1011;
    step(2);
    check("press_hold_early", hold_o, 0);
    step(1);
    check("press_hold_3", hold_o, 1);
    step(2);
    check("press_valid_early", key_valid_o, 0);
    step(1);
    check("press_valid_6", key_valid_o, 1);
    check("press_code", key_code_o, 4'h6);
    check("press_ascii", ascii_o, asc(8'h36));
    step(1);
    check("press_valid_drop", key_valid_o, 0);
    step(13);
    col_i = 4'hF;
    step(5);
    check("rel_hold_still", hold_o, 1);
    step(1);
    check("rel_hold_fall", hold_o, 0);
    check("press_pulses", pulses - base, 1);

    // Reset mid DEB_PRESS: row 2, col 2
    base = pulses;
    row_i = 2'd2;
    col_i = 4'b1011;
    step(4);
    rst_n_i = 1'b0;
    #1;
    check("abort_hold", hold_o, 0);
    check("abort_code", key_code_o, 0);
    check("abort_ascii", ascii_o, 0);
    step(6);
    col_i = 4'hF;
    step(2);
    rst_n_i = 1'b1;
    step(4);
    check("abort_pulses", pulses - base, 0);

    // Press bounce on row 3, col 0 -> code C
    base = pulses;
    row_i = 2'd3;
    for (int i = 0; i < 5; i++) begin
      col_i = 4'b1110;
      step(2);
      col_i = 4'hF;
      step(2);
    end
    check("bounce_none", pulses - base, 0);
    col_i = 4'b1110;
    step(12);
    check("bounce_one", pulses - base, 1);
    check("bounce_code", key_code_o, 4'hC);
    check("bounce_ascii", ascii_o, asc(8'h2A));

    // Release bounce
    base = pulses;
    col_i = 4'hF;
    step(2);
    col_i = 4'b0111;
    step(1);
    col_i = 4'hF;
    step(5);
    check("rb_hold_still", hold_o, 1);
    step(1);
    check("rb_hold_fall", hold_o, 0);
    check("rb_pulses", pulses - base, 0);

    // Multi-key on row 0: extra column never qualifies
    base = pulses;
    row_i = 2'd0;
    col_i = 4'b1001;
    step(10);
    col_i = 4'b1101;
    step(2);
    col_i = 4'hF;
    step(10);
    check("multi_pulses", pulses - base, 0);
    check("multi_code", key_code_o, 4'hC);
    check("multi_hold", hold_o, 0);
    // Single col 1 on row 0 -> code 1
    col_i = 4'b1101;
    step(12);
    check("col1_pulses", pulses - base, 1);
    check("col1_code", key_code_o, 4'h1);
    check("col1_ascii", ascii_o, asc(8'h32));
    col_i = 4'hF;
    step(10);

    // Row change while held
    base = pulses;
    row_i = 2'd2;
    col_i = 4'b1110;
    step(10);
    check("row_code", key_code_o, 4'h8);
    check("row_ascii", ascii_o, asc(8'h37));
    row_i = 2'd3;
    step(6);
    check("row_hold", hold_o, 1);
    check("row_code_kept", key_code_o, 4'h8);
    check("row_pulses", pulses - base, 1);
    col_i = 4'hF;
    step(10);
    check("row_idle", hold_o, 0);

    check("no_consec_valid", consec, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
